// File: rtl/oflow_write_seq_pkg.sv
// Shared types and helpers for the history frame buffer write/read sequencers.
package oflow_write_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Lane offset bundle for the default configuration (2 lanes of 8 bits).
  localparam int DEF_LANES        = 2;
  localparam int DEF_OFFSET_WIDTH = 8;
  typedef logic [DEF_LANES-1:0][DEF_OFFSET_WIDTH-1:0] lane_offsets_t;

  // History slot of a frame: frame mod depth, with a depth of 0 treated as 1.
  function automatic logic [31:0] calc_slot(input logic [31:0] frame,
                                            input logic [31:0] hist);
    logic [31:0] depth;
    depth = (hist == 32'd0) ? 32'd1 : hist;
    return frame % depth;
  endfunction

endpackage

// File: rtl/oflow_slot_select.sv
// Maps a frame number onto a history slot and flags slots outside the table.
module oflow_slot_select
  import oflow_write_seq_pkg::*;
#(
  parameter int TOTAL_FRAME_NUM_WIDTH       = 8,
  parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3,
  parameter int NUM_SLOTS                   = 5
) (
  input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num_i,
  input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] hist_i,
  output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] slot_o,
  output logic                                   in_range_o
);

  logic [31:0] slot_full;

  // The remainder is always below the depth, so it fits the depth width.
  assign slot_full  = calc_slot(32'(frame_num_i), 32'(hist_i));
  assign in_range_o = (slot_full < 32'(NUM_SLOTS));
  assign slot_o     = slot_full[NUM_OF_HISTORY_FRAMES_WIDTH-1:0];

endmodule

// File: rtl/oflow_buffer_write_sequencer.sv
// Emits LANES consecutive frame-buffer offsets per accepted beat for the
// history slot selected by the current frame number.
module oflow_buffer_write_sequencer
  import oflow_write_seq_pkg::*;
#(
  parameter int ADDR_WIDTH                  = 8,
  parameter int OFFSET_WIDTH                = 8,
  parameter int LANES                       = 2,
  parameter int NUM_SLOTS                   = 5,
  parameter int TOTAL_FRAME_NUM_WIDTH       = 8,
  parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3
) (
  input  logic                                   clk,
  input  logic                                   reset_N,
  input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
  input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
  input  logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]   end_pointers,
  input  logic                                   start_write,
  input  logic                                   abort,
  input  logic                                   ready_from_core,
  output logic                                   offset_valid,
  output logic [LANES-1:0][OFFSET_WIDTH-1:0]     offsets,
  output logic [LANES-1:0]                       lane_valid,
  output logic                                   busy,
  output logic                                   done_write,
  output logic                                   slot_error
);

  // One extra bit so base + i and the completion compare never wrap.
  localparam int EW = OFFSET_WIDTH + 1;

  seq_state_t              state_q, state_d;
  logic [OFFSET_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;
  logic                    slot_err_q, slot_err_d;

  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] slot_sel;
  logic                                   slot_ok;
  logic [ADDR_WIDTH-1:0]                  sel_count;
  logic [EW-1:0]                          base_ext, count_ext, next_base_ext;
  logic                                   last_beat;

  oflow_slot_select #(
    .TOTAL_FRAME_NUM_WIDTH      (TOTAL_FRAME_NUM_WIDTH),
    .NUM_OF_HISTORY_FRAMES_WIDTH(NUM_OF_HISTORY_FRAMES_WIDTH),
    .NUM_SLOTS                  (NUM_SLOTS)
  ) u_slot_select (
    .frame_num_i(frame_num),
    .hist_i     (num_of_history_frames),
    .slot_o     (slot_sel),
    .in_range_o (slot_ok)
  );

  // Pick the selected slot's entry count; an out-of-range slot yields zero.
  always_comb begin
    sel_count = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_ok && (int'(slot_sel) == k)) sel_count = end_pointers[k];
    end
  end

  assign base_ext      = {1'b0, base_q};
  assign count_ext     = EW'(count_q);
  assign next_base_ext = base_ext + EW'(LANES);
  assign last_beat     = (next_base_ext >= count_ext);

  // Next-state and datapath update; abort overrides every state.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    slot_err_d = slot_err_q;
    unique case (state_q)
      IDLE: if (start_write) state_d = LOAD;
      LOAD: begin
        base_d     = '0;
        count_d    = sel_count;
        slot_err_d = !slot_ok;
        state_d    = (sel_count == '0) ? DONE : RUN;
      end
      RUN: begin
        if (ready_from_core) begin
          if (last_beat) state_d = DONE;
          else           base_d  = next_base_ext[OFFSET_WIDTH-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      base_d  = '0;
      count_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      slot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      slot_err_q <= slot_err_d;
    end
  end

  // Per-lane offsets; zero outside RUN so idle outputs stay quiet.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [EW-1:0] lane_ext;
    assign lane_ext       = base_ext + EW'(gi);
    assign offsets[gi]    = (state_q == RUN) ? lane_ext[OFFSET_WIDTH-1:0] : '0;
    assign lane_valid[gi] = (state_q == RUN) && (lane_ext < count_ext);
  end

  assign offset_valid = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign done_write   = (state_q == DONE);
  assign slot_error   = (state_q == DONE) && slot_err_q;

endmodule
